cpu_trace_uart: RTL and testbench

Serial trace stage downstream of the Microcontroller. On each capture strobe it snapshots the CPU-visible state (PC, instruction, flags, result) and transmits it as one ASCII text line over an 8N1 UART on a board TXD pin. A host terminal can then log single-stepped execution. It sits beside the LED and seven-segment drivers as a third consumer of the same Microcontroller outputs.

---
 rtl/cpu_trace_uart.sv | 190 +++++++++++++++++++
 tb/tb_cpu_trace_uart.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_uart.sv
// cpu_trace_uart
// Snapshots the CPU-visible state on each accepted capture strobe. It then sends
// that snapshot as one 14-character ASCII line, "PP IIII F RR\r\n", over an
// 8N1 UART.
//
// Ports:
//   i_CLK      system clock, rising edge
//   i_RST      synchronous active-high reset
//   i_Valid    one-cycle capture strobe
//   i_PC       program counter (8)
//   i_INSTR    current instruction (16)
//   i_Z/i_S/i_C/i_OF  ALU flags
//   i_Result   result register (8)
//   o_TXD      UART serial line, idle high (registered)
//   o_Busy     high while a line is in flight (registered)
//   o_Overrun  sticky: a strobe arrived while busy; cleared only by reset
module cpu_trace_uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_Valid,
  input  logic [7:0]  i_PC,
  input  logic [15:0] i_INSTR,
  input  logic        i_Z,
  input  logic        i_S,
  input  logic        i_C,
  input  logic        i_OF,
  input  logic [7:0]  i_Result,
  output logic        o_TXD,
  output logic        o_Busy,
  output logic        o_Overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [15:0] RELOAD   = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_CHR = 4'd13;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
    else           hex_char = 8'h37 + {4'h0, n};
  endfunction

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [3:0]  r_chr;
  logic [7:0]  r_pc;
  logic [15:0] r_instr;
  logic [3:0]  r_flags;
  logic [7:0]  r_res;
  logic        r_txd;
  logic        r_busy;
  logic        r_ovr;

  state_t      w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_bit_nxt;
  logic [3:0]  w_chr_nxt;
  logic        w_txd_nxt;
  logic [7:0]  w_byte;
  logic        w_accept;

  assign w_accept  = i_Valid & ~r_busy;
  assign o_TXD     = r_txd;
  assign o_Busy    = r_busy;
  assign o_Overrun = r_ovr;

  // Character mux. It is indexed by the next character index, so the TXD
  // register loads the right bit on the edge that enters DATA. The snapshot
  // is always settled by then, because at least one START bit of two or
  // more cycles comes first.
  always_comb begin
    w_byte = 8'h0A;
    case (w_chr_nxt)
      4'd0:    w_byte = hex_char(r_pc[7:4]);
      4'd1:    w_byte = hex_char(r_pc[3:0]);
      4'd2:    w_byte = 8'h20;
      4'd3:    w_byte = hex_char(r_instr[15:12]);
      4'd4:    w_byte = hex_char(r_instr[11:8]);
      4'd5:    w_byte = hex_char(r_instr[7:4]);
      4'd6:    w_byte = hex_char(r_instr[3:0]);
      4'd7:    w_byte = 8'h20;
      4'd8:    w_byte = hex_char(r_flags);
      4'd9:    w_byte = 8'h20;
      4'd10:   w_byte = hex_char(r_res[7:4]);
      4'd11:   w_byte = hex_char(r_res[3:0]);
      4'd12:   w_byte = 8'h0D;
      4'd13:   w_byte = 8'h0A;
      default: w_byte = 8'h0A;
    endcase
  end

  // Next-state logic, bit-period counter and next serial-line value.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_chr_nxt   = r_chr;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = RELOAD;
          w_bit_nxt   = 3'd0;
          w_chr_nxt   = 4'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = RELOAD;
          w_bit_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (r_cnt == 16'd0) begin
          w_cnt_nxt = RELOAD;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (r_cnt == 16'd0) begin
          if (r_chr < LAST_CHR) begin
            w_chr_nxt   = r_chr + 4'd1;
            w_state_nxt = S_START;
            w_cnt_nxt   = RELOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_byte[w_bit_nxt];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  // State, snapshot and registered outputs. Reset takes priority over a strobe.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_chr   <= 4'd0;
      r_pc    <= 8'd0;
      r_instr <= 16'd0;
      r_flags <= 4'd0;
      r_res   <= 8'd0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_chr   <= w_chr_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_ovr   <= r_ovr | (i_Valid & r_busy);
      if (w_accept) begin
        r_pc    <= i_PC;
        r_instr <= i_INSTR;
        r_flags <= {i_Z, i_S, i_C, i_OF};
        r_res   <= i_Result;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_uart.sv
// Self-checking bench for cpu_trace_uart.
// A line-level model predicts o_TXD, o_Busy and o_Overrun after every edge.
// It turns the accepted snapshot into its 14-character string and then into
// a 140-bit frame. Completed lines are also decoded from the captured TXD
// samples and compared against literal expected text.
module tb_cpu_trace_uart;
  localparam int C    = 4;
  localparam int LINE = 140 * C;

  logic        clk;
  logic        rst, valid;
  logic [7:0]  pc, res;
  logic [15:0] instr;
  logic        z, s, cf, of;
  logic        txd, busy, ovr;

  int   n_checks = 0;
  int   n_err    = 0;

  logic [7:0] m_line [14];
  int         m_rem = 0;
  int         m_t   = 0;
  logic       m_ovr = 1'b0;
  logic       cap [$];

  cpu_trace_uart #(.CLKS_PER_BIT(C)) dut (
    .i_CLK(clk), .i_RST(rst), .i_Valid(valid),
    .i_PC(pc), .i_INSTR(instr),
    .i_Z(z), .i_S(s), .i_C(cf), .i_OF(of),
    .i_Result(res),
    .o_TXD(txd), .o_Busy(busy), .o_Overrun(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Builds the text the host should see for a snapshot.
  task automatic build_line(input logic [7:0] p, input logic [15:0] in,
                            input logic [3:0] f, input logic [7:0] r);
    string digits;
    digits = "0123456789ABCDEF";
    m_line[0]  = digits[p[7:4]];
    m_line[1]  = digits[p[3:0]];
    m_line[2]  = 8'h20;
    m_line[3]  = digits[in[15:12]];
    m_line[4]  = digits[in[11:8]];
    m_line[5]  = digits[in[7:4]];
    m_line[6]  = digits[in[3:0]];
    m_line[7]  = 8'h20;
    m_line[8]  = digits[f];
    m_line[9]  = 8'h20;
    m_line[10] = digits[r[7:4]];
    m_line[11] = digits[r[3:0]];
    m_line[12] = 8'h0D;
    m_line[13] = 8'h0A;
  endtask

  function automatic logic exp_txd();
    int k, j;
    if (m_rem == 0) return 1'b1;
    k = m_t / (10 * C);
    j = (m_t / C) % 10;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return m_line[k][j-1];
  endfunction

  // One clock: apply controls, advance the model on the edge, then compare.
  task automatic tick(input logic r, input logic v);
    rst   = r;
    valid = v;
    @(posedge clk);
    if (r) begin
      m_rem = 0;
      m_ovr = 1'b0;
    end else begin
      if (v && m_rem > 0) m_ovr = 1'b1;
      if (m_rem > 0) begin
        m_rem--;
        m_t++;
      end else if (v) begin
        build_line(pc, instr, {z, s, cf, of}, res);
        m_rem = LINE;
        m_t   = 0;
      end
    end
    #1;
    check("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
    check("txd", {31'd0, txd}, {31'd0, exp_txd()});
    check("overrun", {31'd0, ovr}, {31'd0, m_ovr});
    if (busy === 1'b1) cap.push_back(txd);
    valid = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic run_line(input logic [7:0] p, input logic [15:0] in, input logic [3:0] f,
                          input logic [7:0] r, input string exp, input int strobe_at,
                          input int rst_at, input bit perturb);
    int n;
    logic [7:0] b;
    pc = p; instr = in; {z, s, cf, of} = f; res = r;
    cap.delete();
    tick(1'b0, 1'b1);
    if (perturb) begin
      pc = 8'hFF; instr = 16'hFFFF; res = 8'h00;
    end
    n = 1;
    while (busy === 1'b1 && n < LINE + 20) begin
      tick(n == rst_at, n == strobe_at);
      if (n == rst_at) break;
      n++;
    end
    check("line_end_idle", {31'd0, busy}, 32'd0);
    if (rst_at == 0) begin
      check("busy_len", cap.size(), LINE);
      for (int k = 0; k < 14; k++) begin
        for (int j = 0; j < 8; j++) begin
          int idx;
          idx = k * 10 * C + (j + 1) * C + C / 2;
          b[j] = (idx < cap.size()) ? cap[idx] : 1'bx;
        end
        check($sformatf("char%0d", k), {24'd0, b}, {24'd0, exp[k]});
        check($sformatf("model_char%0d", k), {24'd0, m_line[k]}, {24'd0, exp[k]});
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0;
    pc = 8'h00; instr = 16'h0000; res = 8'h00;
    z = 1'b0; s = 1'b0; cf = 1'b0; of = 1'b0;

    // Reset with a toggling strobe, then a quiet idle period.
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);

    // Basic line, then snapshot hold with inputs changed after accept.
    run_line(8'h3A, 16'h1F0C, 4'b1010, 8'h7E, "3A 1F0C A 7E\r\n", 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    run_line(8'h3A, 16'h1F0C, 4'b1010, 8'h7E, "3A 1F0C A 7E\r\n", 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);

    // Hex extremes.
    run_line(8'h00, 16'hABCD, 4'b1111, 8'h9F, "00 ABCD F 9F\r\n", 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);

    // Overrun mid-line, then a back-to-back line on the first idle cycle.
    run_line(8'h12, 16'h3456, 4'b0101, 8'hC0, "12 3456 5 C0\r\n", 200, 0, 1'b0);
    run_line(8'hE7, 16'h09B8, 4'b0010, 8'h5D, "E7 09B8 2 5D\r\n", 0, 0, 1'b0);
    check("overrun_sticky", {31'd0, ovr}, 32'd1);

    // Reset during character 5 data bits, then a clean line.
    run_line(8'h44, 16'h5566, 4'b1001, 8'h77, "", 0, 210, 1'b0);
    check("rst_mid_txd", {31'd0, txd}, 32'd1);
    check("rst_mid_ovr", {31'd0, ovr}, 32'd0);
    run_line(8'hB1, 16'hF00D, 4'b0110, 8'h2A, "B1 F00D 6 2A\r\n", 0, 0, 1'b0);

    // Random strobes, inputs and occasional resets against the model.
    for (int i = 0; i < 8000; i++) begin
      pc    = 8'($urandom);
      instr = 16'($urandom);
      res   = 8'($urandom);
      {z, s, cf, of} = 4'($urandom);
      tick($urandom_range(0, 2999) == 0, $urandom_range(0, 59) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
